cmem_seq_ctrl: RTL



---
 rtl/cmem_seq_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/cmem_seq_ctrl.sv
// Compensation-memory sequencer: turns the weight stream into write / change-column / load-done / preload
// controls, then runs the column-parallel preload. Optional sticky protocol checker: CMEM_SEQ_ERR_CHECK_EN.
module cmem_seq_ctrl #(
  parameter int N_COL = 8,
  parameter int N_ROW = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] cw_in,
  input  logic       cw_in_valid,
  output logic       cw_in_ready,
  input  logic       cw_col_end,
  input  logic       cw_col_skip,
  input  logic       preload_req,
  input  logic       cmem_out_valid,
  output logic [2:0] cmem_weight,
  output logic       cmem_wr_valid,
  output logic       cmem_change_col,
  output logic       cmem_load_done,
  output logic       cmem_preload,
  output logic       busy,
  output logic       tile_done,
  output logic       err
);
  localparam int COL_W = $clog2(N_COL + 1);
  localparam int ROW_W = $clog2(N_ROW + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LOADED, S_PRELOAD, S_FLUSH} state_t;

  state_t           state_reg;
  logic [COL_W-1:0] col_cnt_reg;
  logic [ROW_W-1:0] row_cnt_reg;
  logic [ROW_W-1:0] beat_cnt_reg;
  logic             loaded_seen_reg;

  logic [ROW_W-1:0] row_inc;
  logic [ROW_W-1:0] beat_inc;
  logic             last_col;
  logic             col_close;
  logic             col_chg;

  // A beat wins over a skip on the same cycle; the skip is then ignored.
  always_comb begin
    row_inc  = row_cnt_reg + ROW_W'(1);
    beat_inc = beat_cnt_reg + ROW_W'(1);
    last_col = (col_cnt_reg == COL_W'(N_COL - 1));
    if (cw_in_valid) begin
      col_close = cw_col_end || (row_inc == ROW_W'(N_ROW));
      col_chg   = cw_col_end && (row_inc < ROW_W'(N_ROW));
    end else begin
      col_close = cw_col_skip;
      col_chg   = cw_col_skip;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      col_cnt_reg     <= '0;
      row_cnt_reg     <= '0;
      beat_cnt_reg    <= '0;
      loaded_seen_reg <= 1'b0;
      cw_in_ready     <= 1'b0;
      cmem_weight     <= 3'd0;
      cmem_wr_valid   <= 1'b0;
      cmem_change_col <= 1'b0;
      cmem_load_done  <= 1'b0;
      cmem_preload    <= 1'b0;
      busy            <= 1'b0;
      tile_done       <= 1'b0;
    end else begin
      cmem_wr_valid   <= 1'b0;
      cmem_change_col <= 1'b0;
      tile_done       <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg   <= S_LOAD;
            col_cnt_reg <= '0;
            row_cnt_reg <= '0;
            cw_in_ready <= 1'b1;
            busy        <= 1'b1;
          end
        end
        S_LOAD: begin
          if (cw_in_valid) begin
            cmem_wr_valid <= 1'b1;
            cmem_weight   <= cw_in;
          end
          cmem_change_col <= col_chg;
          if (col_close) begin
            row_cnt_reg <= '0;
            if (last_col) begin
              col_cnt_reg     <= '0;
              state_reg       <= S_LOADED;
              cw_in_ready     <= 1'b0;
              loaded_seen_reg <= 1'b0;
            end else begin
              col_cnt_reg <= col_cnt_reg + COL_W'(1);
            end
          end else if (cw_in_valid) begin
            row_cnt_reg <= row_inc;
          end
        end
        // load_done rises one cycle after entry so the final write lands before the index rewinds.
        S_LOADED: begin
          cmem_load_done  <= 1'b1;
          loaded_seen_reg <= 1'b1;
          if (preload_req && loaded_seen_reg) begin
            state_reg    <= S_PRELOAD;
            cmem_preload <= 1'b1;
            beat_cnt_reg <= '0;
          end
        end
        S_PRELOAD: begin
          cmem_load_done <= 1'b1;
          if (cmem_out_valid) begin
            beat_cnt_reg <= beat_inc;
            if (beat_inc == ROW_W'(N_ROW)) begin
              state_reg    <= S_FLUSH;
              cmem_preload <= 1'b0;
            end
          end
        end
        S_FLUSH: begin
          cmem_load_done <= 1'b0;
          busy           <= 1'b0;
          tile_done      <= 1'b1;
          state_reg      <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

`ifdef CMEM_SEQ_ERR_CHECK_EN
  logic err_cond;

  always_comb begin
    err_cond = (cw_in_valid && (state_reg != S_LOAD)) ||
               (cw_col_skip && (cw_in_valid || (state_reg != S_LOAD))) ||
               ((state_reg == S_PRELOAD) && !preload_req);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (err_cond) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
